ffe_coeff_bank_ctrl: RTL

- Double-buffered coefficient store and update scheduler for the FFE tap datapath.
- The host loads new tap coefficients into a shadow bank through a valid/ready port. A commit request swaps the shadow bank into the active bank, but only at a symbol boundary, so one symbol's MAC sequence never mixes old and new taps.
- The FFE controller reads the active bank through rd_en/rd_addr.

---
 rtl/ffe_coeff_bank_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/ffe_coeff_bank_ctrl.sv
// Double-buffered FFE tap coefficient store: the host fills a shadow bank, a commit
// swaps it in at a symbol boundary, then the new active bank is mirrored back into the shadow.
module ffe_coeff_bank_ctrl #(
  parameter int DEPTH      = 4,
  parameter int COEF_WIDTH = 8,
  parameter int ADDR_SIZE  = $clog2(DEPTH)
) (
  input  logic                  ffe_clk,
  input  logic                  rst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ADDR_SIZE-1:0]  cfg_addr,
  input  logic [COEF_WIDTH-1:0] cfg_data,
  input  logic                  cfg_commit,
  output logic                  commit_pending,
  output logic                  commit_done,
  output logic                  err_overrun,
  input  logic                  rd_en,
  input  logic [ADDR_SIZE-1:0]  rd_addr,
  input  logic                  frame_start,
  output logic [COEF_WIDTH-1:0] rd_data,
  output logic                  bank_sel
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_PENDING = 2'd1;
  localparam logic [1:0] ST_COPY    = 2'd2;

  localparam logic [ADDR_SIZE-1:0] LAST_IDX = ADDR_SIZE'(DEPTH - 1);

  logic [1:0]            state_q, state_d;
  logic                  bank_sel_q, bank_sel_d;
  logic                  commit_done_q, commit_done_d;
  logic                  err_overrun_q, err_overrun_d;
  logic [ADDR_SIZE-1:0]  copy_idx_q, copy_idx_d;
  logic [COEF_WIDTH-1:0] bank_q [2][DEPTH];
  logic [COEF_WIDTH-1:0] bank_d [2][DEPTH];

  logic shadow_sel;
  logic safe_point;
  logic cfg_fire;
  logic cfg_addr_ok;
  logic rd_addr_ok;

  assign shadow_sel  = ~bank_sel_q;
  assign safe_point  = !rd_en || frame_start;
  assign cfg_fire    = cfg_valid && cfg_ready;
  assign cfg_addr_ok = int'(cfg_addr) < DEPTH;
  assign rd_addr_ok  = int'(rd_addr) < DEPTH;

  assign cfg_ready      = (state_q == ST_IDLE);
  assign commit_pending = (state_q == ST_PENDING);
  assign commit_done    = commit_done_q;
  assign err_overrun    = err_overrun_q;
  assign bank_sel       = bank_sel_q;

  // Zero-latency read of the active bank; out-of-range or idle reads return zero.
  always_comb begin
    rd_data = '0;
    if (rd_en && rd_addr_ok) begin
      rd_data = bank_q[bank_sel_q][rd_addr];
    end
  end

  always_comb begin
    // NOTE: every combinational output gets a default before the case so no path leaves it unassigned (which would infer a latch).
    state_d       = state_q;
    bank_sel_d    = bank_sel_q;
    commit_done_d = 1'b0;
    err_overrun_d = err_overrun_q | (cfg_commit && (state_q != ST_IDLE));
    copy_idx_d    = copy_idx_q;
    bank_d        = bank_q;

    case (state_q)
      ST_IDLE: begin
        // A write in the same cycle as the commit lands before the swap and is included.
        if (cfg_fire && cfg_addr_ok) begin
          bank_d[shadow_sel][cfg_addr] = cfg_data;
        end
        if (cfg_commit) begin
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (safe_point) begin
          bank_sel_d    = ~bank_sel_q;
          commit_done_d = 1'b1;
          state_d       = ST_COPY;
        end
      end
      ST_COPY: begin
        // bank_sel has already flipped, so this refreshes the old bank from the new taps.
        bank_d[shadow_sel][copy_idx_q] = bank_q[bank_sel_q][copy_idx_q];
        if (copy_idx_q == LAST_IDX) begin
          copy_idx_d = '0;
          state_d    = ST_IDLE;
        end else begin
          copy_idx_d = copy_idx_q + ADDR_SIZE'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: the coefficient banks are reset on purpose; after reset the datapath must see zero taps, not stale values.
  always_ff @(posedge ffe_clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      bank_sel_q    <= 1'b0;
      commit_done_q <= 1'b0;
      err_overrun_q <= 1'b0;
      copy_idx_q    <= '0;
      for (int b = 0; b < 2; b++) begin
        for (int i = 0; i < DEPTH; i++) begin
          bank_q[b][i] <= '0;
        end
      end
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the pre-edge values of the others.
      state_q       <= state_d;
      bank_sel_q    <= bank_sel_d;
      commit_done_q <= commit_done_d;
      err_overrun_q <= err_overrun_d;
      copy_idx_q    <= copy_idx_d;
      bank_q        <= bank_d;
    end
  end

endmodule
